// File: rtl/sdram_init_checker.sv
// Passive monitor for the SDRAM power-up sequence: wait, PRECHARGE ALL, N x AUTO REFRESH, MRS.
// Define SDRAM_CHK_TIMING_EN to add tRP/tRFC command-gap checking (error code 3).
module sdram_init_checker #(
    parameter int WAIT_CYCLES = 10000,
    parameter int TRP_CYCLES  = 1,
    parameter int TRFC_CYCLES = 4,
    parameter int REF_COUNT   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sdram_cmd,
    input  logic [11:0] sdram_addr,
    output logic        init_done,
    output logic        init_err,
    output logic [2:0]  err_code,
    output logic [2:0]  mode_bl,
    output logic        mode_bt,
    output logic [2:0]  mode_cl,
    output logic [3:0]  ref_cnt,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        WAIT_PWR = 3'd0,
        WAIT_PRE = 3'd1,
        WAIT_REF = 3'd2,
        WAIT_MRS = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } state_t;

    localparam logic [3:0]  CMD_PRE   = 4'b0010;
    localparam logic [3:0]  CMD_AREF  = 4'b0001;
    localparam logic [3:0]  CMD_NOP   = 4'b0111;
    localparam logic [3:0]  CMD_MRS   = 4'b0000;
    localparam logic [2:0]  ERR_EARLY = 3'd1;
    localparam logic [2:0]  ERR_ORDER = 3'd2;
    localparam logic [2:0]  ERR_TIME  = 3'd3;
    localparam logic [2:0]  ERR_MODE  = 3'd4;
    localparam logic [13:0] WAIT_LAST = 14'(WAIT_CYCLES - 1);
    localparam logic [4:0]  REF_TGT   = 5'(REF_COUNT);

    state_t      r_state;
    logic [13:0] r_pwr_cnt;
    logic [3:0]  r_ref_cnt;
    logic        r_init_done;
    logic        r_init_err;
    logic [2:0]  r_err_code;
    logic [2:0]  r_mode_bl;
    logic        r_mode_bt;
    logic [2:0]  r_mode_cl;

    logic        w_is_cmd;
    logic        w_is_pre;
    logic        w_is_aref;
    logic        w_is_mrs;
    logic        w_mode_bad;
    logic [3:0]  w_ref_sat;
    logic        w_ref_reached;
    logic        w_timing_bad;
    logic        w_unused_addr;

    // Deselect (cs_n high) and NOP are both idle; anything else is a command.
    assign w_is_cmd  = !sdram_cmd[3] && (sdram_cmd != CMD_NOP);
    assign w_is_pre  = (sdram_cmd == CMD_PRE);
    assign w_is_aref = (sdram_cmd == CMD_AREF);
    assign w_is_mrs  = (sdram_cmd == CMD_MRS);

    assign w_mode_bad = !((sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3)) ||
                        !((sdram_addr[2:0] <= 3'd3) || (sdram_addr[2:0] == 3'd7));

    assign w_ref_sat     = (r_ref_cnt == 4'hF) ? 4'hF : r_ref_cnt + 4'd1;
    assign w_ref_reached = ({1'b0, r_ref_cnt} + 5'd1) == REF_TGT;
    assign w_unused_addr = ^{sdram_addr[11], sdram_addr[9:7]};

`ifdef SDRAM_CHK_TIMING_EN
    localparam logic [7:0] TRP_GAP  = 8'(TRP_CYCLES);
    localparam logic [7:0] TRFC_GAP = 8'(TRFC_CYCLES);

    logic [7:0] r_gap;
    logic       r_last_pre;
    logic       r_last_aref;

    // r_gap holds cycles since the previous command, so back-to-back commands see 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap       <= 8'd0;
            r_last_pre  <= 1'b0;
            r_last_aref <= 1'b0;
        end else if (w_is_cmd) begin
            r_gap       <= 8'd1;
            r_last_pre  <= w_is_pre;
            r_last_aref <= w_is_aref;
        end else if (r_gap != 8'hFF) begin
            r_gap <= r_gap + 8'd1;
        end
    end

    assign w_timing_bad = (r_last_pre && (r_gap < TRP_GAP)) ||
                          (r_last_aref && (r_gap < TRFC_GAP));
`else
    logic w_unused_timing;
    assign w_unused_timing = (TRP_CYCLES > 0) ^ (TRFC_CYCLES > 0);
    assign w_timing_bad    = 1'b0;
`endif

    // Error checks inside each state are ordered so that code 1 > 2 > 4 > 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WAIT_PWR;
            r_pwr_cnt   <= 14'd0;
            r_ref_cnt   <= 4'd0;
            r_init_done <= 1'b0;
            r_init_err  <= 1'b0;
            r_err_code  <= 3'd0;
            r_mode_bl   <= 3'd0;
            r_mode_bt   <= 1'b0;
            r_mode_cl   <= 3'd0;
        end else begin
            case (r_state)
                WAIT_PWR: begin
                    if (w_is_cmd) begin
                        r_state    <= ERROR;
                        r_init_err <= 1'b1;
                        r_err_code <= ERR_EARLY;
                    end else if (r_pwr_cnt == WAIT_LAST) begin
                        r_state <= WAIT_PRE;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + 14'd1;
                    end
                end
                WAIT_PRE: begin
                    if (w_is_cmd) begin
                        if (!w_is_pre || !sdram_addr[10]) begin
                            r_state    <= ERROR;
                            r_init_err <= 1'b1;
                            r_err_code <= ERR_ORDER;
                        end else if (w_timing_bad) begin
                            r_state    <= ERROR;
                            r_init_err <= 1'b1;
                            r_err_code <= ERR_TIME;
                        end else begin
                            r_state <= WAIT_REF;
                        end
                    end
                end
                WAIT_REF: begin
                    if (w_is_cmd) begin
                        if (!w_is_aref) begin
                            r_state    <= ERROR;
                            r_init_err <= 1'b1;
                            r_err_code <= ERR_ORDER;
                        end else if (w_timing_bad) begin
                            r_state    <= ERROR;
                            r_init_err <= 1'b1;
                            r_err_code <= ERR_TIME;
                        end else begin
                            r_ref_cnt <= w_ref_sat;
                            if (w_ref_reached) begin
                                r_state <= WAIT_MRS;
                            end
                        end
                    end
                end
                WAIT_MRS: begin
                    if (w_is_aref) begin
                        if (w_timing_bad) begin
                            r_state    <= ERROR;
                            r_init_err <= 1'b1;
                            r_err_code <= ERR_TIME;
                        end else begin
                            r_ref_cnt <= w_ref_sat;
                        end
                    end else if (w_is_mrs) begin
                        // Mode fields are captured even when the MRS itself is rejected.
                        r_mode_bl <= sdram_addr[2:0];
                        r_mode_bt <= sdram_addr[3];
                        r_mode_cl <= sdram_addr[6:4];
                        if (w_mode_bad) begin
                            r_state    <= ERROR;
                            r_init_err <= 1'b1;
                            r_err_code <= ERR_MODE;
                        end else if (w_timing_bad) begin
                            r_state    <= ERROR;
                            r_init_err <= 1'b1;
                            r_err_code <= ERR_TIME;
                        end else begin
                            r_state     <= DONE;
                            r_init_done <= 1'b1;
                        end
                    end else if (w_is_cmd) begin
                        r_state    <= ERROR;
                        r_init_err <= 1'b1;
                        r_err_code <= ERR_ORDER;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign init_done   = r_init_done;
    assign init_err    = r_init_err;
    assign err_code    = r_err_code;
    assign mode_bl     = r_mode_bl;
    assign mode_bt     = r_mode_bt;
    assign mode_cl     = r_mode_cl;
    assign ref_cnt     = r_ref_cnt;
    assign o_dbg_state = r_state;

endmodule
